flash_sample_seq: RTL and testbench

//  Sequences 32-bit word reads from the audio flash and emits one 16-bit PCM sample per sample_tick.

---
 rtl/flash_seq_pkg.sv | 25 ++
 rtl/wrap_addr_ctr.sv | 43 ++++
 rtl/flash_sample_seq.sv | 143 ++++++++++++++
 tb/tb_flash_sample_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_seq_pkg.sv
// Shared types and constants for the flash sample sequencer.
package flash_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_D,
        HALF
    } seq_state_t;

    localparam logic FWD = 1'b1;
    localparam logic REV = 1'b0;

    localparam int          ADDR_W_DEF   = 23;
    localparam logic [22:0] END_ADDR_DEF = 23'h7FFFF;

    // Select the upper or lower 16-bit half of a flash word.
    function automatic logic [15:0] pick_half(
        input logic [31:0] w,
        input logic        upper
    );
        return upper ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/wrap_addr_ctr.sv
// Up/down word-address counter that wraps between 0 and END_ADDR.
module wrap_addr_ctr
    import flash_seq_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              up,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (en) begin
            if (up) begin
                addr_d = (addr_q == END_ADDR) ? '0 : addr_q + 1'b1;
            end else begin
                addr_d = (addr_q == '0) ? END_ADDR : addr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/flash_sample_seq.sv
// Fetches 32-bit flash words and plays them out as two 16-bit PCM samples,
// one per sample tick, honouring play/pause, direction and restart.
module flash_sample_seq
    import flash_seq_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(END_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              playpause,
    input  logic              dir,
    input  logic              restart,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [15:0]       audio_out,
    output logic              sample_valid
);

    seq_state_t  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic        wdir_q, wdir_d;
    logic [15:0] audio_q, audio_d;
    logic        valid_q, valid_d;
    logic        pending_q, pending_d;
    logic        rreq_q, rreq_d;

    logic              ctr_en;
    logic              ctr_load;
    logic [ADDR_W-1:0] ctr_val;
    logic              eff_tick;

    assign eff_tick = sample_tick | pending_q;

    wrap_addr_ctr #(
        .ADDR_W   (ADDR_W),
        .END_ADDR (END_ADDR)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (ctr_en),
        .load     (ctr_load),
        .load_val (ctr_val),
        .up       (dir),
        .addr     (flash_addr)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        wdir_d     = wdir_q;
        audio_d    = audio_q;
        valid_d    = 1'b0;
        pending_d  = pending_q;
        rreq_d     = rreq_q;
        ctr_en     = 1'b0;
        ctr_load   = 1'b0;
        ctr_val    = dir ? '0 : END_ADDR;
        flash_read = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The tick check here consumes pending whether or not we play.
                pending_d = 1'b0;
                if (restart) begin
                    ctr_load = 1'b1;
                    rreq_d   = 1'b0;
                end
                if (eff_tick && playpause) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                flash_read = 1'b1;
                if (sample_tick) pending_d = 1'b1;
                if (restart)     rreq_d    = 1'b1;
                if (!flash_waitrequest) begin
                    state_d = WAIT_D;
                end
            end
            WAIT_D: begin
                if (sample_tick) pending_d = 1'b1;
                if (restart)     rreq_d    = 1'b1;
                if (flash_readdatavalid) begin
                    word_d  = flash_readdata;
                    wdir_d  = dir;
                    audio_d = pick_half(flash_readdata, dir == REV);
                    valid_d = 1'b1;
                    state_d = HALF;
                end
            end
            HALF: begin
                // Hold off one cycle after the first half so valid never doubles.
                if (eff_tick && !valid_q) begin
                    audio_d   = pick_half(word_q, wdir_q == FWD);
                    valid_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = IDLE;
                    if (rreq_q || restart) begin
                        ctr_load = 1'b1;
                        rreq_d   = 1'b0;
                    end else begin
                        ctr_en = 1'b1;
                    end
                end else begin
                    if (sample_tick) pending_d = 1'b1;
                    if (restart)     rreq_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            wdir_q    <= FWD;
            audio_q   <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            rreq_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            wdir_q    <= wdir_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            rreq_q    <= rreq_d;
        end
    end

    assign audio_out    = audio_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_flash_sample_seq.sv
// Directed testbench for flash_sample_seq with a scripted Avalon flash.
module tb_flash_sample_seq;

    localparam logic [22:0] ENDA = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        playpause;
    logic        dir;
    logic        restart;
    logic        flash_read;
    logic [22:0] flash_addr;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] audio_out;
    logic        sample_valid;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flash_read && !flash_waitrequest) n_acc <= n_acc + 1;
    end

    flash_sample_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_tick         (sample_tick),
        .playpause           (playpause),
        .dir                 (dir),
        .restart             (restart),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_out           (audio_out),
        .sample_valid        (sample_valid)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Called at the negedge of the first FETCH cycle.
    task automatic serve(input logic [31:0] w, input int waits,
                         input int lat, input bit rs, input int tick_at);
        logic [22:0] a0;
        a0 = flash_addr;
        flash_waitrequest = 1'b1;
        for (int i = 0; i < waits; i++) begin
            sample_tick = (i == tick_at);
            step();
            checks++;
            if (flash_read !== 1'b1 || flash_addr !== a0) begin
                errors++;
                $display("FAIL wr_hold cyc %0d: read=%b addr=%h, need read=1 addr=%h",
                         i, flash_read, flash_addr, a0);
            end
        end
        sample_tick = 1'b0;
        flash_waitrequest = 1'b0;
        step();
        flash_waitrequest = 1'b1;
        restart = rs;
        repeat (lat - 1) begin
            step();
            restart = 1'b0;
        end
        flash_readdatavalid = 1'b1;
        flash_readdata = w;
        step();
        restart = 1'b0;
        flash_readdatavalid = 1'b0;
        flash_readdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (flash_read !== 1'b0 || audio_out !== 16'h0 ||
            sample_valid !== 1'b0 || flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL reset: read=%b audio=%h valid=%b addr=%h, need 0/0/0/0",
                     flash_read, audio_out, sample_valid, flash_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fwd();
        playpause = 1'b1;
        dir = 1'b1;
        tick();
        checks++;
        if (flash_read !== 1'b1 || flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL fwd_fetch: read=%b addr=%h, need 1 and 0",
                     flash_read, flash_addr);
        end
        serve(32'hBEEF_1234, 0, 2, 0, -1);
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'h1234) begin
            errors++;
            $display("FAIL fwd_first: valid=%b audio=%h, need 1 and 1234",
                     sample_valid, audio_out);
        end
        step();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_pulse: valid=%b, need 0", sample_valid);
        end
        tick();
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'hBEEF ||
            flash_addr !== 23'h1) begin
            errors++;
            $display("FAIL fwd_second: valid=%b audio=%h addr=%h, need 1 BEEF 1",
                     sample_valid, audio_out, flash_addr);
        end
    endtask

    task automatic test_rev();
        step();
        dir = 1'b1;
        do_restart();
        checks++;
        if (flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL idle_restart: addr=%h, need 0", flash_addr);
        end
        dir = 1'b0;
        tick();
        serve(32'hBEEF_1234, 0, 2, 0, -1);
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL rev_first: valid=%b audio=%h, need 1 BEEF",
                     sample_valid, audio_out);
        end
        step();
        tick();
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'h1234 ||
            flash_addr !== ENDA) begin
            errors++;
            $display("FAIL rev_second: valid=%b audio=%h addr=%h, need 1 1234 7ffff",
                     sample_valid, audio_out, flash_addr);
        end
    endtask

    task automatic test_wrap();
        step();
        dir = 1'b1;
        tick();
        serve(32'h0000_0001, 0, 1, 0, -1);
        step();
        tick();
        checks++;
        if (flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL fwd_wrap: addr=%h, need 0", flash_addr);
        end
        step();
        dir = 1'b0;
        do_restart();
        checks++;
        if (flash_addr !== ENDA) begin
            errors++;
            $display("FAIL rev_restart: addr=%h, need 7ffff", flash_addr);
        end
        tick();
        serve(32'h0000_0002, 0, 1, 0, -1);
        step();
        tick();
        checks++;
        if (flash_addr !== 23'h7FFFE) begin
            errors++;
            $display("FAIL rev_dec: addr=%h, need 7fffe", flash_addr);
        end
    endtask

    task automatic test_waitreq();
        int acc0;
        step();
        dir = 1'b1;
        tick();
        acc0 = n_acc;
        serve(32'h1111_2222, 5, 2, 0, 2);
        checks++;
        if (n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL one_accept: accepts=%0d, need 1", n_acc - acc0);
        end
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'h2222) begin
            errors++;
            $display("FAIL wr_first: valid=%b audio=%h, need 1 2222",
                     sample_valid, audio_out);
        end
        step();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_gap: valid=%b, need 0", sample_valid);
        end
        step();
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'h1111 ||
            flash_addr !== ENDA) begin
            errors++;
            $display("FAIL pending_half: valid=%b audio=%h addr=%h, need 1 1111 7ffff",
                     sample_valid, audio_out, flash_addr);
        end
    endtask

    task automatic test_pause();
        int bad;
        step();
        dir = 1'b1;
        do_restart();
        tick();
        serve(32'hCAFE_F00D, 0, 2, 0, -1);
        checks++;
        if (audio_out !== 16'hF00D) begin
            errors++;
            $display("FAIL pause_first: audio=%h, need F00D", audio_out);
        end
        playpause = 1'b0;
        step();
        tick();
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'hCAFE) begin
            errors++;
            $display("FAIL pause_half: valid=%b audio=%h, need 1 CAFE",
                     sample_valid, audio_out);
        end
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sample_valid !== 1'b0 || flash_read !== 1'b0) bad++;
            step();
            if (sample_valid !== 1'b0 || flash_read !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || audio_out !== 16'hCAFE) begin
            errors++;
            $display("FAIL paused: bad=%0d audio=%h, need 0 CAFE", bad, audio_out);
        end
        playpause = 1'b1;
        tick();
        checks++;
        if (flash_read !== 1'b1 || flash_addr !== 23'h1) begin
            errors++;
            $display("FAIL resume: read=%b addr=%h, need 1 and 1",
                     flash_read, flash_addr);
        end
        serve(32'h0, 0, 1, 0, -1);
        step();
        tick();
    endtask

    task automatic test_restart();
        step();
        dir = 1'b1;
        do_restart();
        for (int i = 0; i < 256; i++) begin
            tick();
            serve(32'(i), 0, 1, 0, -1);
            step();
            tick();
        end
        checks++;
        if (flash_addr !== 23'h100) begin
            errors++;
            $display("FAIL walk: addr=%h, need 100", flash_addr);
        end
        tick();
        serve(32'h5555_AAAA, 0, 2, 1, -1);
        checks++;
        if (sample_valid !== 1'b1 || audio_out !== 16'hAAAA ||
            flash_addr !== 23'h100) begin
            errors++;
            $display("FAIL rs_first: valid=%b audio=%h addr=%h, need 1 AAAA 100",
                     sample_valid, audio_out, flash_addr);
        end
        step();
        tick();
        checks++;
        if (audio_out !== 16'h5555 || flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL rs_apply: audio=%h addr=%h, need 5555 0",
                     audio_out, flash_addr);
        end
    endtask

    task automatic test_rst_fetch();
        step();
        dir = 1'b1;
        tick();
        tick();
        checks++;
        if (flash_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: read=%b, need 1", flash_read);
        end
        rst = 1'b1;
        step();
        checks++;
        if (flash_read !== 1'b0 || audio_out !== 16'h0 ||
            sample_valid !== 1'b0 || flash_addr !== 23'h0) begin
            errors++;
            $display("FAIL rst_fetch: read=%b audio=%h valid=%b addr=%h, need 0s",
                     flash_read, audio_out, sample_valid, flash_addr);
        end
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        sample_tick = 1'b0;
        playpause = 1'b0;
        dir = 1'b1;
        restart = 1'b0;
        flash_waitrequest = 1'b1;
        flash_readdata = '0;
        flash_readdatavalid = 1'b0;
        test_reset();
        test_fwd();
        test_rev();
        test_wrap();
        test_waitreq();
        test_pause();
        test_restart();
        test_rst_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
